// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter that shares one register-bank write port between NREQ
// requesters, issuing at most one registered write and one grant pulse per cycle.
module regbank_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int AW    = 3,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  we,
  output logic [AW-1:0]         waddr,
  output logic [WIDTH-1:0]      wdata,
  output logic [7:0]            wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = PW + 1;

  // Handshake: req[i] is a valid that must stay asserted, with addr/data
  // stable, until gnt[i] pulses high for one cycle; gnt is the ready. In the
  // gnt cycle the requester may drop req or present its next write. Dropping
  // req before the grant withdraws the request with no side effect.

  logic [NREQ-1:0]  r_gnt;
  logic             r_we;
  logic [AW-1:0]    r_waddr;
  logic [WIDTH-1:0] r_wdata;
  logic [7:0]       r_cnt;
  logic [PW-1:0]    r_ptr;

  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [SW-1:0]    w_sum;
  logic [PW-1:0]    w_cand;
  logic [NREQ-1:0]  w_onehot;
  logic [PW-1:0]    w_next_ptr;

  // The requester granted last cycle is masked so it cannot win back-to-back.
  assign w_elig = req & ~r_gnt;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + SW'(i);
      if (w_sum >= SW'(NREQ)) begin
        w_sum = w_sum - SW'(NREQ);
      end
      w_cand = w_sum[PW-1:0];
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
  assign w_next_ptr = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else if (hold || !w_found) begin
      r_gnt <= '0;
      r_we  <= 1'b0;
    end else begin
      r_gnt   <= w_onehot;
      r_we    <= 1'b1;
      r_waddr <= addr[w_win*AW +: AW];
      r_wdata <= data[w_win*WIDTH +: WIDTH];
      r_ptr   <= w_next_ptr;
      r_cnt   <= r_cnt + 8'd1;
    end
  end

  assign gnt      = r_gnt;
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign wr_count = r_cnt;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: directed scenarios plus random traffic checked
// against a round-robin reference model and an expected-value queue.
module tb_regbank_wr_arbiter;

  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int NREQ  = 4;
  localparam int EW    = NREQ + 1 + AW + WIDTH + 8;

  logic                  clk;
  logic                  reset;
  logic                  hold;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [WIDTH-1:0]      wdata;
  logic [7:0]            wr_count;

  regbank_wr_arbiter #(.WIDTH(WIDTH), .AW(AW), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .hold(hold), .req(req), .addr(addr),
    .data(data), .gnt(gnt), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_count(wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: pointer, last winner (-1 = none), write count, write port
  int               m_ptr;
  int               m_prev;
  int               m_cnt;
  logic [NREQ-1:0]  m_gnt;
  logic             m_we;
  logic [AW-1:0]    m_waddr;
  logic [WIDTH-1:0] m_wdata;

  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_prev = -1; m_cnt = 0;
    m_gnt = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // One arbitration decision from the current inputs, in list terms:
  // scan requesters starting at the pointer, skipping last cycle's winner.
  task automatic model_edge();
    int k;
    k = -1;
    if (!hold) begin
      for (int off = 0; off < NREQ; off++) begin
        int c;
        c = (m_ptr + off) % NREQ;
        if (k < 0 && req[c] && c != m_prev) k = c;
      end
    end
    if (k < 0) begin
      m_gnt = '0; m_we = 1'b0; m_prev = -1;
    end else begin
      m_gnt   = '0;
      m_gnt[k] = 1'b1;
      m_we    = 1'b1;
      m_waddr = addr[k*AW +: AW];
      m_wdata = data[k*WIDTH +: WIDTH];
      m_ptr   = (k + 1) % NREQ;
      m_cnt   = (m_cnt + 1) % 256;
      m_prev  = k;
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    addr[i*AW +: AW]       = a;
    data[i*WIDTH +: WIDTH] = d;
  endtask

  // Advance one edge and score the DUT against the model's prediction.
  task automatic step();
    logic [EW-1:0] e;
    model_edge();
    exp_q.push_back({m_gnt, m_we, m_waddr, m_wdata, 8'(m_cnt)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("gnt",      32'(gnt),      32'(e[EW-1 -: NREQ]));
    check("we",       32'(we),       32'(e[AW+WIDTH+8]));
    check("waddr",    32'(waddr),    32'(e[WIDTH+8 +: AW]));
    check("wdata",    32'(wdata),    32'(e[8 +: WIDTH]));
    check("wr_count", 32'(wr_count), 32'(e[7:0]));
    check("onehot",   32'($onehot0(gnt)), 32'(1));
    check("we_or",    32'(we),       32'(|gnt));
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b0; hold = 1'b0; req = '0; addr = '0; data = '0;
    model_reset();
    do_reset();
    check("reset_gnt", 32'(gnt), 32'(0));
    check("reset_cnt", 32'(wr_count), 32'(0));

    // reset mid-grant clears outputs without a clock edge
    set_req(0, 3'd5, 8'hA5);
    req = 4'b0001;
    step();
    check("pre_rst_we", 32'(we), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("arst_gnt",   32'(gnt),      32'(0));
    check("arst_we",    32'(we),       32'(0));
    check("arst_waddr", 32'(waddr),    32'(0));
    check("arst_wdata", 32'(wdata),    32'(0));
    check("arst_cnt",   32'(wr_count), 32'(0));
    req = '0;
    do_reset();

    // single requester: grant, then masked, alternating
    req = 4'b0001;
    step();
    check("single_gnt",   32'(gnt),   32'(4'b0001));
    check("single_waddr", 32'(waddr), 32'(5));
    check("single_wdata", 32'(wdata), 32'(8'hA5));
    step();
    check("single_mask", 32'(we), 32'(0));
    step();
    check("single_again", 32'(gnt), 32'(4'b0001));
    step();
    req = '0;
    do_reset();

    // round robin from reset
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i + 1), 8'(8'h10 * (i + 1)));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_order", 32'(gnt), 32'(1 << exp_order[i]));
    end
    check("rr_count", 32'(wr_count), 32'(5));

    // continue to a grant on 3, then pointer wraps
    step(); step(); step();
    check("to_3", 32'(gnt), 32'(4'b1000));
    req = 4'b1001;
    step();
    check("wrap_0", 32'(gnt), 32'(4'b0001));
    step();
    check("wrap_3", 32'(gnt), 32'(4'b1000));

    // hold freezes arbitration, pointer and count
    hold = 1'b1;
    req  = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_gnt", 32'(gnt), 32'(0));
      check("hold_cnt", 32'(wr_count), 32'(10));
    end
    hold = 1'b0;
    step();
    check("hold_release", 32'(gnt), 32'(4'b0010));
    req = '0;
    step();

    // counter wrap after 256 grants
    do_reset();
    req = 4'b1111;
    repeat (255) step();
    check("cnt_255", 32'(wr_count), 32'(255));
    step();
    check("cnt_wrap", 32'(wr_count), 32'(0));

    // random traffic
    req = '0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      req  = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 3) == 0) set_req(i, 3'($urandom), 8'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
